// File: rtl/aes_word_stream_if_if.sv
// Word-stream bus between the glue logic and the AES word front end:
// the key-write port, the plaintext input stream and the ciphertext output stream.
interface aes_word_stream_if_if;
   logic        key_wr;
   logic [31:0] key_wdata;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   modport master (
      output key_wr, key_wdata, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  key_wr, key_wdata, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/aes_word_stream_if.sv
// Gathers four 32-bit plaintext words and a four-word key for a 128-bit AES-ECB
// core, starts it, and serialises the captured ciphertext back out as four words.
module aes_word_stream_if #(
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   aes_word_stream_if_if.slave  bus,
   output logic                 aes_start,
   input  logic                 aes_ready,
   input  logic                 aes_valid,
   output logic [127:0]         aes_plaintext,
   output logic [127:0]         aes_key,
   input  logic [127:0]         aes_ciphertext,
   output logic                 busy,
   output logic                 err,
   input  logic                 err_clr
);

   typedef enum logic [1:0] {S_FILL, S_START, S_WAIT, S_DRAIN} state_t;

   state_t       state;
   logic [1:0]   wcnt;
   logic [1:0]   rcnt;
   logic [1:0]   key_idx;
   logic [7:0]   tcnt;
   logic [127:0] ct;

   // Handshake outputs depend on state alone; only aes_start looks at aes_ready.
   assign bus.in_ready  = (state == S_FILL);
   assign bus.out_valid = (state == S_DRAIN);
   assign busy          = (state == S_START) || (state == S_WAIT);
   assign aes_start     = (state == S_START) && aes_ready;

   // Word slot n lives at bits [127-32n -: 32]; {~n, 5'd0} is that slot's LSB.
   assign bus.out_data  = ct[{~rcnt, 5'd0} +: 32];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_FILL;
         wcnt          <= '0;
         rcnt          <= '0;
         key_idx       <= '0;
         tcnt          <= '0;
         ct            <= '0;
         aes_plaintext <= '0;
         aes_key       <= '0;
         err           <= 1'b0;
      end else begin
         // A timeout in the same cycle overrides this clear further down.
         if (err_clr)
            err <= 1'b0;

         // The key is frozen while the core owns it.
         if (bus.key_wr && (state == S_FILL || state == S_DRAIN)) begin
            aes_key[{~key_idx, 5'd0} +: 32] <= bus.key_wdata;
            key_idx                         <= key_idx + 2'd1;
         end

         case (state)
            S_FILL: begin
               if (bus.in_valid) begin
                  aes_plaintext[{~wcnt, 5'd0} +: 32] <= bus.in_data;
                  if (wcnt == 2'd3) begin
                     wcnt  <= '0;
                     state <= S_START;
                  end else begin
                     wcnt <= wcnt + 2'd1;
                  end
               end
            end
            S_START: begin
               if (aes_ready)
                  state <= S_WAIT;
            end
            S_WAIT: begin
               if (aes_valid) begin
                  ct    <= aes_ciphertext;
                  tcnt  <= '0;
                  state <= S_DRAIN;
               end else if (tcnt == 8'(TIMEOUT - 1)) begin
                  err   <= 1'b1;
                  tcnt  <= '0;
                  state <= S_FILL;
               end else begin
                  tcnt <= tcnt + 8'd1;
               end
            end
            S_DRAIN: begin
               if (bus.out_ready) begin
                  if (rcnt == 2'd3) begin
                     rcnt  <= '0;
                     state <= S_FILL;
                  end else begin
                     rcnt <= rcnt + 2'd1;
                  end
               end
            end
            default: state <= S_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_word_stream_if.sv
// Bench for aes_word_stream_if: behavioural AES-128 core model plus a reference
// that tracks the key slots and block contents from the bus-level rules.
module tb_aes_word_stream_if;

   logic         clk = 1'b0;
   logic         rst;
   logic         aes_start, aes_ready, aes_valid;
   logic [127:0] aes_plaintext, aes_key, aes_ciphertext;
   logic         busy, err, err_clr;

   aes_word_stream_if_if bus ();

   aes_word_stream_if #(.TIMEOUT(64)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .aes_start      (aes_start),
      .aes_ready      (aes_ready),
      .aes_valid      (aes_valid),
      .aes_plaintext  (aes_plaintext),
      .aes_key        (aes_key),
      .aes_ciphertext (aes_ciphertext),
      .busy           (busy),
      .err            (err),
      .err_clr        (err_clr)
   );

   always #5 clk = ~clk;

   int ntot  = 0;
   int npass = 0;

   logic [127:0] fips_key = 128'h000102030405060708090a0b0c0d0e0f;
   logic [127:0] fips_pt  = 128'h00112233445566778899aabbccddeeff;
   logic [127:0] fips_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   // ---------------- AES-128 reference ----------------
   logic [7:0] sb [256];

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = (b << n) | (b >> (8 - n));
      return r;
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  tmp;
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
            rc  = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) begin
         tmp  = w[i/4];
         s[i] = pt[127-8*i -: 8] ^ tmp[31-8*(i%4) -: 8];
      end
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
               s[rr+4*c] = t[rr+4*((c+rr)%4)];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int i = 0; i < 16; i++) begin
            tmp  = w[4*r + i/4];
            s[i] = s[i] ^ tmp[31-8*(i%4) -: 8];
         end
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // ---------------- Core model ----------------
   logic         core_active;
   int           core_cnt;
   int           core_lat;
   logic         core_mute;
   logic         ready_block;
   int           core_starts;
   logic [127:0] core_ct;

   assign aes_ready      = !core_active && !ready_block;
   assign aes_ciphertext = core_ct;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         core_active <= 1'b0;
         core_cnt    <= 0;
         aes_valid   <= 1'b0;
         core_ct     <= '0;
         core_starts <= 0;
      end else begin
         aes_valid <= 1'b0;
         if (aes_start && aes_ready) begin
            core_active <= 1'b1;
            core_cnt    <= core_lat;
            core_ct     <= aes_enc(aes_key, aes_plaintext);
            core_starts <= core_starts + 1;
         end else if (core_active) begin
            if (core_cnt <= 1) begin
               core_active <= 1'b0;
               aes_valid   <= !core_mute;
            end else begin
               core_cnt <= core_cnt - 1;
            end
         end
      end
   end

   // ---------------- Reference key state ----------------
   logic [31:0] km [4];
   int          kidx;

   function automatic logic [127:0] key_model();
      return {km[0], km[1], km[2], km[3]};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic write_key(input logic [31:0] w, input bit taken);
      bus.key_wr    = 1'b1;
      bus.key_wdata = w;
      @(negedge clk);
      bus.key_wr    = 1'b0;
      if (taken) begin
         km[kidx] = w;
         kidx     = (kidx + 1) % 4;
      end
   endtask

   task automatic send_block(input logic [127:0] pt);
      for (int k = 0; k < 4; k++) begin
         int n = 0;
         bus.in_valid = 1'b1;
         bus.in_data  = pt[127-32*k -: 32];
         while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (n >= 100) chk("in_ready wait", 128'(n < 100), 128'(1));
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
   endtask

   // mode 0: always ready; mode 1: ten stalled cycles then toggling.
   task automatic drain(output logic [127:0] got, input int mode, input int nwords);
      int          hs = 0;
      int          cyc = 0;
      logic [31:0] prev = '0;
      logic        pending = 1'b0;
      got = '0;
      while (hs < nwords && cyc < 400) begin
         bus.out_ready = (mode == 0) ? 1'b1 : ((cyc < 10) ? 1'b0 : 1'(cyc % 2));
         if (pending) chk("hold while stalled", {bus.out_valid, bus.out_data}, {1'b1, prev});
         if (bus.out_valid && bus.out_ready) begin
            got[127-32*hs -: 32] = bus.out_data;
            hs++;
         end
         pending = bus.out_valid && !bus.out_ready;
         prev    = bus.out_data;
         @(negedge clk);
         cyc++;
      end
      bus.out_ready = 1'b0;
      if (hs < nwords) chk("drain handshakes", 128'(hs), 128'(nwords));
   endtask

   initial begin
      logic [127:0] got, pt;
      int           n, s0;

      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         logic [7:0] b;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b     = inv;
         sb[x] = b ^ rol8(b, 1) ^ rol8(b, 2) ^ rol8(b, 3) ^ rol8(b, 4) ^ 8'h63;
      end

      rst = 1'b1; err_clr = 1'b0;
      bus.key_wr = 1'b0; bus.key_wdata = '0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      ready_block = 1'b0; core_mute = 1'b0; core_lat = 3;
      for (int i = 0; i < 4; i++) km[i] = '0;
      kidx = 0;

      repeat (2) @(negedge clk);
      chk("reset in_ready", 128'(bus.in_ready), 128'(1));
      chk("reset out_valid", 128'(bus.out_valid), 128'(0));
      chk("reset busy", 128'(busy), 128'(0));
      chk("reset err", 128'(err), 128'(0));
      chk("reset aes_start", 128'(aes_start), 128'(0));
      chk("reset aes_key", aes_key, 128'(0));
      chk("reset aes_plaintext", aes_plaintext, 128'(0));
      rst = 1'b0;
      @(negedge clk);

      // FIPS-197 vector with latency checks
      for (int i = 0; i < 4; i++) write_key(fips_key[127-32*i -: 32], 1'b1);
      chk("fips key loaded", aes_key, key_model());
      send_block(fips_pt);
      chk("start latency", 128'(aes_start), 128'(1));
      chk("busy in start", 128'(busy), 128'(1));
      chk("plaintext to core", aes_plaintext, fips_pt);
      n = 0;
      while (!aes_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("aes_valid seen", 128'(aes_valid), 128'(1));
      chk("out_valid before capture", 128'(bus.out_valid), 128'(0));
      @(negedge clk);
      chk("out_valid latency", 128'(bus.out_valid), 128'(1));
      chk("first word latency", 128'(bus.out_data), 128'(fips_ct[127:96]));
      drain(got, 0, 4);
      chk("fips ciphertext", got, fips_ct);
      chk("fips err", 128'(err), 128'(0));
      chk("back-to-back in_ready", 128'(bus.in_ready), 128'(1));
      chk("no fifth word", 128'(bus.out_valid), 128'(0));

      // Output backpressure
      pt = {$urandom, $urandom, $urandom, $urandom};
      send_block(pt);
      drain(got, 1, 4);
      chk("backpressure block", got, aes_enc(key_model(), pt));
      chk("backpressure end", 128'(bus.out_valid), 128'(0));

      // Start gating
      ready_block = 1'b1;
      pt = {$urandom, $urandom, $urandom, $urandom};
      send_block(pt);
      s0 = core_starts;
      for (int i = 0; i < 5; i++) begin
         chk("gated aes_start", 128'(aes_start), 128'(0));
         chk("gated busy", 128'(busy), 128'(1));
         @(negedge clk);
      end
      ready_block = 1'b0;
      #1;
      chk("released aes_start", 128'(aes_start), 128'(1));
      @(negedge clk);
      chk("start pulse width", 128'(aes_start), 128'(0));
      chk("busy in wait", 128'(busy), 128'(1));
      chk("single start", 128'(core_starts - s0), 128'(1));
      drain(got, 0, 4);
      chk("gated block", got, aes_enc(key_model(), pt));

      // Key write while busy, FIPS key still in place
      core_lat = 6;
      send_block(fips_pt);
      @(negedge clk);
      chk("busy before key write", 128'(busy), 128'(1));
      write_key(32'hdeadbeef, 1'b0);
      chk("key frozen while busy", aes_key, key_model());
      drain(got, 0, 4);
      chk("fips after ignored write", got, fips_ct);
      write_key(32'h01234567, 1'b1);
      chk("key_idx unchanged", aes_key, key_model());

      // Timeout with a clear held across the expiry
      core_mute = 1'b1;
      core_lat  = 3;
      pt = {$urandom, $urandom, $urandom, $urandom};
      send_block(pt);
      err_clr = 1'b1;
      @(negedge clk);
      chk("wait entry busy", 128'(busy), 128'(1));
      n = 0;
      while (!err && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("timeout cycles", 128'(n), 128'(64));
      err_clr = 1'b0;
      chk("in_ready after timeout", 128'(bus.in_ready), 128'(1));
      @(negedge clk);
      chk("err sticky", 128'(err), 128'(1));
      chk("in_ready following cycle", 128'(bus.in_ready), 128'(1));
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err cleared", 128'(err), 128'(0));
      core_mute = 1'b0;

      // Randomized blocks with partial key updates
      for (int b = 0; b < 6; b++) begin
         int nk = $urandom_range(0, 3);
         for (int k = 0; k < nk; k++) write_key($urandom, 1'b1);
         core_lat = $urandom_range(1, 8);
         pt = {$urandom, $urandom, $urandom, $urandom};
         send_block(pt);
         drain(got, b % 2, 4);
         chk("random block", got, aes_enc(key_model(), pt));
      end
      chk("random err", 128'(err), 128'(0));

      // Reset mid-drain
      core_lat = 2;
      pt = {$urandom, $urandom, $urandom, $urandom};
      send_block(pt);
      drain(got, 0, 2);
      chk("partial drain", got[127:64], aes_enc(key_model(), pt) >> 64);
      rst = 1'b1;
      #1;
      chk("rst out_valid", 128'(bus.out_valid), 128'(0));
      chk("rst in_ready", 128'(bus.in_ready), 128'(1));
      chk("rst busy", 128'(busy), 128'(0));
      for (int i = 0; i < 4; i++) km[i] = '0;
      kidx = 0;
      chk("rst key", aes_key, key_model());
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) write_key(fips_key[127-32*i -: 32], 1'b1);
      send_block(fips_pt);
      drain(got, 0, 4);
      chk("fips after reset", got, fips_ct);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global timeout: checks %0d of %0d passed", npass, ntot);
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/aes_word_stream_if.md
Name: aes_word_stream_if

Overview:
- 32-bit word-stream front end for the 128-bit AES-ECB core.
- Upstream: gathers four plaintext words and a four-word key from a valid/ready stream and a key-write port, then pulses the core's start input.
- Downstream: captures the 128-bit ciphertext when the core signals valid, then serialises it back out as four words over valid/ready.
- Sits between the bus-side glue logic and the AES core.

Parameters:
- TIMEOUT, 64, maximum cycles in S_WAIT before the error flag is set and the FSM aborts to S_FILL (legal range 2..255).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- key_wr  in  1  key word write strobe
- key_wdata  in  32  key word; the first write after reset or wrap is bits [127:96]
- in_valid  in  1  plaintext word valid
- in_ready  out  1  plaintext word accepted when in_valid and in_ready are both high
- in_data  in  32  plaintext word, most-significant word first
- out_valid  out  1  ciphertext word valid
- out_ready  in  1  ciphertext word consumed when out_valid and out_ready are both high
- out_data  out  32  ciphertext word, most-significant word first
- aes_start  out  1  one-cycle start pulse to the core
- aes_ready  in  1  core idle, able to accept start
- aes_valid  in  1  core ciphertext valid (one-cycle pulse)
- aes_plaintext  out  128  registered plaintext to the core
- aes_key  out  128  registered key to the core
- aes_ciphertext  in  128  core result
- busy  out  1  high in S_START and S_WAIT
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err

Behaviour:
- Clock/reset: single clock clk. rst is asynchronous and active-high.
- On rst, all registers go to 0, including the plaintext, key, ciphertext, word counters, key_idx, timeout counter and err.
- After rst, state = S_FILL. Resulting outputs: in_ready=1, out_valid=0, aes_start=0, busy=0, err=0.
- States: S_FILL, S_START, S_WAIT, S_DRAIN. Next state is registered; in_ready, out_valid and busy are decoded from state only.
- S_FILL:
  - in_ready=1.
  - Each accepted word is shifted into the plaintext register at slot wcnt: word 0 goes to [127:96], word 3 to [31:0]. wcnt then increments.
  - Acceptance of word 3 (wcnt==3) moves to S_START and clears wcnt.
- S_START:
  - aes_start = aes_ready (combinational in this state only). The pulse lasts exactly one cycle.
  - If aes_ready=1, move to S_WAIT next cycle. Otherwise stay in S_START.
  - Latency: word 3 accepted at cycle N; aes_start is seen at N+1 at the earliest.
- S_WAIT:
  - The timeout counter increments each cycle.
  - On aes_valid=1: capture aes_ciphertext, clear the counter, go to S_DRAIN.
  - If the counter reaches TIMEOUT-1 without aes_valid: set err, clear the counter, go to S_FILL. The plaintext is discarded; the next fill starts at word 0.
- S_DRAIN:
  - out_valid=1. out_data = ciphertext slot rcnt, MSW first.
  - out_data must be held stable while out_ready=0.
  - Each handshake increments rcnt. The handshake with rcnt==3 returns to S_FILL and clears rcnt.
  - Latency: aes_valid at cycle M gives out_valid=1 with word 0 at M+1.
- aes_valid outside S_WAIT is ignored and the ciphertext register is unchanged.
- Key port:
  - In S_FILL or S_DRAIN, key_wr writes key_wdata to key slot key_idx, then key_idx = (key_idx+1) mod 4.
  - In S_START or S_WAIT, key_wr is ignored and key_idx is unchanged, so aes_key is stable for the whole operation.
  - A partially written key is used as-is; no key-complete gating.
- aes_plaintext is stable from S_START until S_FILL is re-entered.
- err: err_clr clears it. If set and clear happen in the same cycle, set wins. err does not block operation.
- Back-to-back operation: the cycle after the last out handshake, in_ready=1. The fill of block k+1 is not overlapped with the drain of block k.
- Asynchronous rst mid-operation (any state): immediate return to S_FILL with all counters at 0. A pending core result is lost; the core shares rst.

Test Plan:
- FIPS-197 vector:
  - Stimulus: key words 00010203, 04050607, 08090a0b, 0c0d0e0f; plaintext 00112233, 44556677, 8899aabb, ccddeeff; real core attached.
  - Required: out_data sequence 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; err=0.
- Output backpressure:
  - Stimulus: out_ready=0 for 10 cycles, then toggling.
  - Required: out_data and out_valid held stable throughout; exactly 4 handshakes; words in order.
- Start gating:
  - Stimulus: core model holds aes_ready=0 for 5 cycles after the fill completes.
  - Required: aes_start=0 throughout; a single 1-cycle aes_start on the first aes_ready=1 cycle; busy=1 from S_START onward.
- Timeout:
  - Stimulus: core model never asserts aes_valid, TIMEOUT=64.
  - Required: err=1 exactly 64 cycles after S_WAIT entry; in_ready=1 the following cycle; err_clr pulse returns err to 0.
- Key write during busy:
  - Stimulus: key_wr with 0xdeadbeef while in S_WAIT.
  - Required: aes_key unchanged, key_idx unchanged, ciphertext still matches the FIPS vector.
- Reset mid-drain:
  - Stimulus: rst pulse after 2 output words.
  - Required: out_valid=0 immediately; in_ready=1; the next block's 4 words produce the correct ciphertext from word 0.
